// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register map, ip bit positions,
// access-port states and the byte-strobe merge helper.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;

  localparam int IP_MSIP = 3;
  localparam int IP_MTIP = 7;
  localparam int IP_SEIP = 9;
  localparam int IP_MEIP = 11;

  typedef enum logic {
    CLINT_IDLE,
    CLINT_RESP
  } clint_state_e;

  function automatic logic [63:0] merge64(input logic [63:0] old,
                                          input logic [63:0] wdata,
                                          input logic [7:0]  wstrb);
    logic [63:0] res;
    res = old;
    for (int i = 0; i < 8; i++) begin
      if (wstrb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_sync.sv
// Single-bit multi-flop synchroniser for asynchronous interrupt lines.
module clint_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[DEPTH-2:0], d};
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a req/ack register port, plus
// synchronised external interrupts, producing the ip and time vectors for the CSR file.
module clint
  import clint_pkg::*;
#(
  parameter int TICK_DIV   = 1,
  parameter int SYNC_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wstrb,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        ack,
  output logic        err,
  input  logic        ext_meip,
  input  logic        ext_seip,
  output logic [63:0] ip,
  output logic [63:0] time_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  clint_state_e  state, state_next;
  logic [63:0]   mtime, mtimecmp, read_val;
  logic [PW-1:0] presc;
  logic          msip, mtip, meip_s, seip_s;
  logic          tick, access, wr;
  logic          hit_msip, hit_cmp, hit_time, bad_addr;

  assign tick = (presc == PRESC_MAX);

  always_comb begin
    state_next = state;
    access     = 1'b0;
    case (state)
      CLINT_IDLE: begin
        if (req) begin
          state_next = CLINT_RESP;
          access     = 1'b1;
        end
      end
      CLINT_RESP: state_next = CLINT_IDLE;
      default:    state_next = CLINT_IDLE;
    endcase
  end

  // Misaligned offsets never match a map entry, so they fall out as bad_addr too.
  always_comb begin
    hit_msip = (addr == CLINT_MSIP);
    hit_cmp  = (addr == CLINT_MTIMECMP);
    hit_time = (addr == CLINT_MTIME);
    bad_addr = !(hit_msip || hit_cmp || hit_time);
    read_val = '0;
    if (hit_msip)     read_val = {63'd0, msip};
    else if (hit_cmp) read_val = mtimecmp;
    else if (hit_time) read_val = mtime;
  end

  assign wr = access && we && !bad_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLINT_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack   <= access;
      err   <= access && bad_addr;
      rdata <= (access && !we && !bad_addr) ? read_val : '0;
    end
  end

  // A real mtime write overrides the tick; the prescaler keeps its own cadence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
      msip     <= 1'b0;
      mtip     <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (wr && hit_time && (wstrb != 8'h00)) mtime <= merge64(mtime, wdata, wstrb);
      else if (tick)                          mtime <= mtime + 64'd1;
      if (wr && hit_cmp) mtimecmp <= merge64(mtimecmp, wdata, wstrb);
      if (wr && hit_msip && wstrb[0]) msip <= wdata[0];
      mtip <= (mtime >= mtimecmp);
    end
  end

  clint_sync #(.DEPTH(SYNC_DEPTH)) u_sync_meip (
    .clk (clk),
    .rst (rst),
    .d   (ext_meip),
    .q   (meip_s)
  );

  clint_sync #(.DEPTH(SYNC_DEPTH)) u_sync_seip (
    .clk (clk),
    .rst (rst),
    .d   (ext_seip),
    .q   (seip_s)
  );

  always_comb begin
    ip          = '0;
    ip[IP_MSIP] = msip;
    ip[IP_MTIP] = mtip;
    ip[IP_SEIP] = seip_s;
    ip[IP_MEIP] = meip_s;
  end

  assign time_o = mtime;

endmodule
